axis_arbiter: RTL and testbench
===============================

AXIS_ARBITER -- requirements
Module: axis_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter DRAIN_TIMEOUT, default 8'd255, max cycles in DRAIN waiting for bk_done.
REQ-003 Port axi_aclk  input  1  sole clock, all logic on rising edge.
REQ-004 Port axi_aresetn  input  1  asynchronous active-low reset.
REQ-005 Ports req_valid/req_last/req_ready  in/in/out  N_REQ each  per-requester beat valid, packet end, accept.
REQ-006 Ports req_data/req_tstrb/req_tkeep/req_user  input  N_REQ x 32/4/4/2  per-requester beat payload.
REQ-007 Ports bk_start/bk_data/bk_tstrb/bk_tkeep/bk_user  output  1/32/4/4/2  backend write into axis master.
REQ-008 Ports bk_nordy, bk_done  input  1 each  master tready-timeout stall flag; master transaction end pulse.
REQ-009 Ports grant  output  N_REQ  one-hot current owner; busy  output  1  state != IDLE.
REQ-010 Port timeout_err  output  1  sticky, set on DRAIN timeout; err_clr  input  1  clears it.

Function
REQ-011 States IDLE, XFER, DRAIN; only these three reachable.
REQ-012 IDLE: any req_valid -> latch round-robin winner into grant, go XFER next cycle; req_ready all 0, bk_start 0.
REQ-013 Round-robin search starts at index last_owner+1, wraps N_REQ-1 -> 0; last_owner resets to N_REQ-1 (index 0 wins first).
REQ-014 XFER: req_ready[g] = ~bk_nordy; others 0; bk_start = req_valid[g] & ~bk_nordy; bk_* payload = requester g payload combinationally.
REQ-015 Beat accepted when req_valid[g] & req_ready[g]; bk_start is high exactly for accepted beats, zero latency.
REQ-016 bk_* payload outputs SHALL be 0 whenever bk_start is 0.
REQ-017 bk_nordy high: stall, no beat accepted, state and grant held; resume on first cycle bk_nordy low.
REQ-018 Accepted beat with req_last[g]=1 -> DRAIN next cycle; bk_done in XFER ignored (mid-packet FIFO underrun).
REQ-019 DRAIN: req_ready all 0; wait for bk_done; on bk_done -> IDLE, last_owner <= g, grant <= 0.
REQ-020 DRAIN cycle counter, 8-bit, cleared on DRAIN entry; reaching DRAIN_TIMEOUT without bk_done -> IDLE, last_owner <= g, timeout_err <= 1.
REQ-021 bk_done and counter == DRAIN_TIMEOUT same cycle: treated as normal done, timeout_err unchanged.
REQ-022 err_clr and timeout set same cycle: set wins.
REQ-023 Requester dropping req_valid mid-packet in XFER: grant held, no beats, no timeout in XFER.
REQ-024 Arbitration latency: IDLE with valid request -> first possible beat 1 cycle later; back-to-back packets separated by >= 2 idle beat cycles (DRAIN exit + IDLE).

Reset
REQ-025 axi_aresetn low: state IDLE, grant 0, last_owner N_REQ-1, counter 0, timeout_err 0, all req_ready and bk_* outputs 0, busy 0.
REQ-026 Reset mid-XFER/DRAIN aborts immediately; no partial-packet completion after release.

Structure
REQ-027 Package axis_arb_pkg holds state enum typedef, DRAIN_TIMEOUT default, payload widths (32/4/4/2).
REQ-028 Sub-module rr_pick: combinational round-robin picker (req vector, last index -> one-hot winner, any flag).
REQ-029 Total RTL 150-300 lines; no internal data buffering.

Verification
REQ-030 Req 0 and 2 valid at reset release -> grant=4'b0001 first, 3 beats with last on beat 3, bk_done -> next grant=4'b0100.
REQ-031 All 4 requesting continuously, 1-beat packets, bk_done 2 cycles after DRAIN entry -> grant order 0,1,2,3,0.
REQ-032 bk_nordy high 6 cycles mid-packet (data 32'hA5A5_0001..0004) -> req_ready 0 and bk_start 0 for those 6 cycles; all 4 beats delivered in order, none duplicated.
REQ-033 No bk_done after last beat -> IDLE after 255 DRAIN cycles, timeout_err=1 until err_clr pulse; err_clr+timeout same cycle -> stays 1.
REQ-034 bk_done pulse in XFER after beat 1 of 4 -> state stays XFER, remaining 3 beats accepted.
REQ-035 axi_aresetn asserted mid-XFER -> all outputs 0 same cycle; after release, request from 3 only -> grant=4'b1000.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI-Stream packet arbiter.
package axis_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned KEEP_W = 4;
  localparam int unsigned USER_W = 2;
  localparam int unsigned CNT_W  = 8;

  // Default number of DRAIN cycles allowed before giving up on bk_done
  localparam logic [CNT_W-1:0] DRAIN_TIMEOUT_DEF = 8'd255;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_XFER  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  // One beat of payload forwarded to the backend
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] tstrb;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] user;
  } axis_beat_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last_i+1 upward with wrap.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     win_oh_c,
  output logic [IDX_W-1:0] win_idx_c,
  output logic             any_c
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // First requester at or after last_i+1 (mod N) wins; last_i itself is tried last
  always_comb begin
    win_oh_c  = '0;
    win_idx_c = '0;
    any_c     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(last_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (!any_c && req_i[cand_idx]) begin
        any_c              = 1'b1;
        win_idx_c          = cand_idx;
        win_oh_c[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_arbiter.sv
// Packet-level round-robin arbiter steering N_REQ AXI-Stream sources onto one backend.
module axis_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned      N_REQ         = 4,
  parameter logic [CNT_W-1:0] DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
  input  logic [N_REQ-1:0][STRB_W-1:0]  req_tstrb,
  input  logic [N_REQ-1:0][KEEP_W-1:0]  req_tkeep,
  input  logic [N_REQ-1:0][USER_W-1:0]  req_user,
  output logic                          bk_start,
  output logic [DATA_W-1:0]             bk_data,
  output logic [STRB_W-1:0]             bk_tstrb,
  output logic [KEEP_W-1:0]             bk_tkeep,
  output logic [USER_W-1:0]             bk_user,
  input  logic                          bk_nordy,
  input  logic                          bk_done,
  output logic [N_REQ-1:0]              grant,
  output logic                          busy,
  output logic                          timeout_err,
  input  logic                          err_clr
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'(ARB_IDLE);
  localparam logic [1:0] ST_XFER  = 2'(ARB_XFER);
  localparam logic [1:0] ST_DRAIN = 2'(ARB_DRAIN);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             err_q,   err_d;
  logic             err_set;

  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  axis_beat_t       beat_sel;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i     (req_valid),
    .last_i    (last_q),
    .win_oh_c  (pick_oh),
    .win_idx_c (pick_idx),
    .any_c     (pick_any)
  );

  // State, ownership, drain counter and sticky error registers
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic plus the zero-latency pass-through of the owner's beats
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_set   = 1'b0;
    req_ready = '0;
    bk_start  = 1'b0;
    beat_sel  = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_XFER;
          grant_d = pick_oh;
          owner_d = pick_idx;
        end
      end

      ST_XFER: begin
        // bk_done is ignored here: it signals a mid-packet backend underrun
        req_ready[owner_q] = ~bk_nordy;
        bk_start           = req_valid[owner_q] & ~bk_nordy;
        if (bk_start) begin
          beat_sel.data  = req_data[owner_q];
          beat_sel.tstrb = req_tstrb[owner_q];
          beat_sel.tkeep = req_tkeep[owner_q];
          beat_sel.user  = req_user[owner_q];
          if (req_last[owner_q]) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end
        end
      end

      ST_DRAIN: begin
        // cnt_q holds the number of DRAIN cycles already spent before this one
        if (bk_done) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end else if (cnt_q == DRAIN_TIMEOUT - CNT_W'(1)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_q;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    // A new timeout outranks a simultaneous clear
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  assign bk_data     = beat_sel.data;
  assign bk_tstrb    = beat_sel.tstrb;
  assign bk_tkeep    = beat_sel.tkeep;
  assign bk_user     = beat_sel.user;
  assign grant       = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_axis_arbiter.sv
// Directed bench for axis_arbiter with hand-computed expectations.
module tb_axis_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_last;
  logic [3:0]       req_ready;
  logic [3:0][31:0] req_data;
  logic [3:0][3:0]  req_tstrb;
  logic [3:0][3:0]  req_tkeep;
  logic [3:0][1:0]  req_user;
  logic             bk_start;
  logic [31:0]      bk_data;
  logic [3:0]       bk_tstrb;
  logic [3:0]       bk_tkeep;
  logic [1:0]       bk_user;
  logic             bk_nordy;
  logic             bk_done;
  logic [3:0]       grant;
  logic             busy;
  logic             timeout_err;
  logic             err_clr;

  int total = 0;
  int bad   = 0;

  axis_arbiter #(
    .N_REQ         (4),
    .DRAIN_TIMEOUT (8'd255)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_tstrb   (req_tstrb),
    .req_tkeep   (req_tkeep),
    .req_user    (req_user),
    .bk_start    (bk_start),
    .bk_data     (bk_data),
    .bk_tstrb    (bk_tstrb),
    .bk_tkeep    (bk_tkeep),
    .bk_user     (bk_user),
    .bk_nordy    (bk_nordy),
    .bk_done     (bk_done),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_last  = '0;
    bk_nordy  = 1'b0;
    bk_done   = 1'b0;
    err_clr   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_data[i]  = 32'hD000_0000 | 32'(i);
      req_tstrb[i] = 4'hF;
      req_tkeep[i] = 4'hF;
      req_user[i]  = 2'(i);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_start"}, 32'(bk_start), 32'h0);
    chk({tag, "_data"}, bk_data, 32'h0);
    chk({tag, "_side"}, 32'({bk_tstrb, bk_tkeep, bk_user}), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order [5];
    logic [3:0] exp_g;
    logic exp_start;
    int beat, cyc, nordy_cnt, n;

    order = '{0, 1, 2, 3, 0};

    // Reset state, with requests already pending
    rst_n = 1'b0;
    clear_inputs();
    req_valid = 4'b0101;
    repeat (3) tick();
    chk_quiet("rst");
    chk("rst_err", 32'(timeout_err), 32'h0);

    // Requesters 0 and 2 at release: 0 first (3 beats), then 2
    rst_n = 1'b1;
    #1;
    chk("t1_idle_ready", 32'(req_ready), 32'h0);
    chk("t1_idle_start", 32'(bk_start), 32'h0);
    tick();
    req_data[0] = 32'hAAAA_0001;
    #1;
    chk("t1_grant0", 32'(grant), 32'h1);
    chk("t1_ready0", 32'(req_ready), 32'h1);
    chk("t1_b1_start", 32'(bk_start), 32'h1);
    chk("t1_b1_data", bk_data, 32'hAAAA_0001);
    tick();
    req_data[0] = 32'hAAAA_0002;
    #1;
    chk("t1_b2_data", bk_data, 32'hAAAA_0002);
    tick();
    req_data[0] = 32'hAAAA_0003;
    req_last[0] = 1'b1;
    #1;
    chk("t1_b3_data", bk_data, 32'hAAAA_0003);
    tick();
    req_last[0] = 1'b0;
    #1;
    chk("t1_drain_busy", 32'(busy), 32'h1);
    chk("t1_drain_ready", 32'(req_ready), 32'h0);
    chk("t1_drain_start", 32'(bk_start), 32'h0);
    chk("t1_drain_data", bk_data, 32'h0);
    bk_done = 1'b1;
    tick();
    bk_done = 1'b0;
    #1;
    chk("t1_idle_grant", 32'(grant), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_idle_start2", 32'(bk_start), 32'h0);
    tick();
    req_last[2] = 1'b1;
    req_data[2] = 32'hBBBB_0001;
    #1;
    chk("t1_grant2", 32'(grant), 32'h4);
    chk("t1_r2_data", bk_data, 32'hBBBB_0001);
    tick();
    req_valid = '0;
    req_last  = '0;
    bk_done   = 1'b1;
    tick();
    bk_done = 1'b0;
    #1;
    chk("t1_end_busy", 32'(busy), 32'h0);

    // All four requesting single-beat packets: strict rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i] = 32'hC0DE_0000 | 32'(i);
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      exp_g = 4'b0001 << order[k];
      chk("t2_grant", 32'(grant), 32'(exp_g));
      chk("t2_data", bk_data, 32'hC0DE_0000 | 32'(order[k]));
      tick();
      tick();
      tick();
      bk_done = 1'b1;
      tick();
      bk_done = 1'b0;
      #1;
      chk("t2_idle_busy", 32'(busy), 32'h0);
    end
    req_valid = '0;
    req_last  = '0;

    // Backend stall of 6 cycles in the middle of a 4-beat packet
    do_reset();
    req_valid = 4'b0010;
    beat = 0;
    cyc = 0;
    nordy_cnt = 0;
    tick();
    while (beat < 4 && cyc < 30) begin
      req_data[1] = 32'hA5A5_0001 + 32'(beat);
      req_last[1] = (beat == 3);
      bk_nordy    = (cyc >= 2 && cyc <= 7);
      exp_start   = !(cyc >= 2 && cyc <= 7);
      #1;
      chk("t3_start", 32'(bk_start), 32'(exp_start));
      if (bk_nordy) begin
        chk("t3_stall_ready", 32'(req_ready), 32'h0);
        chk("t3_stall_grant", 32'(grant), 32'h2);
        nordy_cnt++;
      end
      if (bk_start) begin
        chk("t3_data", bk_data, 32'hA5A5_0001 + 32'(beat));
        beat++;
      end
      cyc++;
      tick();
    end
    bk_nordy  = 1'b0;
    req_valid = '0;
    req_last  = '0;
    chk("t3_beats", 32'(beat), 32'd4);
    chk("t3_cycles", 32'(cyc), 32'd10);
    chk("t3_stalls", 32'(nordy_cnt), 32'd6);

    // No bk_done after the last beat: timeout after 255 DRAIN cycles
    #1;
    chk("t4_pre_err", 32'(timeout_err), 32'h0);
    chk("t4_pre_busy", 32'(busy), 32'h1);
    n = 0;
    while (busy && n < 400) begin
      n++;
      tick();
    end
    chk("t4_drain_len", 32'(n), 32'd255);
    chk("t4_err_set", 32'(timeout_err), 32'h1);
    chk("t4_grant0", 32'(grant), 32'h0);
    repeat (3) tick();
    chk("t4_err_sticky", 32'(timeout_err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("t4_err_clr", 32'(timeout_err), 32'h0);

    // Clear and timeout in the same cycle: set wins
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    tick();
    #1;
    chk("t4b_grant", 32'(grant), 32'h2);
    tick();
    req_valid = '0;
    req_last  = '0;
    n = 0;
    while (busy && n < 400) begin
      err_clr = (n == 254);
      n++;
      tick();
    end
    err_clr = 1'b0;
    #1;
    chk("t4b_drain_len", 32'(n), 32'd255);
    chk("t4b_set_wins", 32'(timeout_err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // bk_done coincident with the limit counts as a normal completion
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    tick();
    tick();
    req_valid = '0;
    req_last  = '0;
    n = 0;
    while (busy && n < 400) begin
      bk_done = (n == 254);
      n++;
      tick();
    end
    bk_done = 1'b0;
    #1;
    chk("t4c_drain_len", 32'(n), 32'd255);
    chk("t4c_no_err", 32'(timeout_err), 32'h0);

    // bk_done mid-packet ignored; source pausing mid-packet keeps the grant
    req_valid   = 4'b0100;
    req_data[2] = 32'hE000_0001;
    tick();
    #1;
    chk("t5_grant", 32'(grant), 32'h4);
    chk("t5_b1_start", 32'(bk_start), 32'h1);
    tick();
    bk_done     = 1'b1;
    req_data[2] = 32'hE000_0002;
    #1;
    chk("t5_b2_start", 32'(bk_start), 32'h1);
    chk("t5_b2_data", bk_data, 32'hE000_0002);
    tick();
    bk_done   = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_gap_start", 32'(bk_start), 32'h0);
      chk("t5_gap_grant", 32'(grant), 32'h4);
      chk("t5_gap_ready", 32'(req_ready), 32'h4);
      tick();
    end
    req_valid   = 4'b0100;
    req_data[2] = 32'hE000_0003;
    #1;
    chk("t5_b3_data", bk_data, 32'hE000_0003);
    tick();
    req_data[2] = 32'hE000_0004;
    req_last[2] = 1'b1;
    #1;
    chk("t5_b4_data", bk_data, 32'hE000_0004);
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    chk("t5_drain_busy", 32'(busy), 32'h1);
    chk("t5_drain_ready", 32'(req_ready), 32'h0);
    bk_done = 1'b1;
    tick();
    bk_done = 1'b0;
    #1;
    chk("t5_end_busy", 32'(busy), 32'h0);

    // Reset in the middle of a transfer, then only requester 3
    req_valid   = 4'b0001;
    req_data[0] = 32'hF00D_0001;
    tick();
    #1;
    chk("t6_grant0", 32'(grant), 32'h1);
    chk("t6_start", 32'(bk_start), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_quiet("t6_rst");
    tick();
    tick();
    req_valid    = 4'b1000;
    req_last     = 4'b1000;
    req_data[3]  = 32'h3333_0001;
    req_tstrb[3] = 4'h3;
    req_tkeep[3] = 4'h7;
    req_user[3]  = 2'b10;
    rst_n = 1'b1;
    #1;
    chk("t6_rel_busy", 32'(busy), 32'h0);
    tick();
    #1;
    chk("t6_grant3", 32'(grant), 32'h8);
    chk("t6_start3", 32'(bk_start), 32'h1);
    chk("t6_data3", bk_data, 32'h3333_0001);
    chk("t6_side3", 32'({bk_tstrb, bk_tkeep, bk_user}), 32'({4'h3, 4'h7, 2'b10}));
    tick();
    req_valid = '0;
    req_last  = '0;
    bk_done   = 1'b1;
    tick();
    bk_done = 1'b0;
    #1;
    chk("t6_end_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
